// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encodings, instruction field
// positions and the sequencer FSM state type.
package alu_pkg;

   localparam int INSTR_W = 8;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int RS_MSB  = 4;
   localparam int RS_LSB  = 3;
   localparam int RT_MSB  = 2;
   localparam int RT_LSB  = 1;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_ADD  = 3'b000;
   localparam opcode_t OP_SUB  = 3'b001;
   localparam opcode_t OP_AND  = 3'b010;
   localparam opcode_t OP_OR   = 3'b011;
   localparam opcode_t OP_XOR  = 3'b100;
   localparam opcode_t OP_SET  = 3'b101;
   localparam opcode_t OP_SHL  = 3'b110;
   localparam opcode_t OP_ZERO = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Flag-only opcodes leave the register file untouched.
   function automatic logic op_writes_reg(input opcode_t op);
      return !((op == OP_SET) || (op == OP_ZERO));
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake between a host (master) and the sequencer (slave).
interface alu_sequencer_if;
   import alu_pkg::*;

   logic                 instr_valid_i;
   logic [INSTR_W-1:0]   instr_i;
   logic                 instr_ready_o;

   modport master (output instr_valid_i, output instr_i, input instr_ready_o);
   modport slave  (input instr_valid_i, input instr_i, output instr_ready_o);

endinterface

// File: rtl/alu_regfile.sv
// General register file: one synchronous write port, three combinational read
// ports, asynchronous active-low clear.
module alu_regfile #(
   parameter int REGS = 4,
   parameter int W    = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    we_i,
   input  logic [$clog2(REGS)-1:0] waddr_i,
   input  logic [W-1:0]            wdata_i,
   input  logic [$clog2(REGS)-1:0] ra0_i,
   output logic [W-1:0]            rd0_o,
   input  logic [$clog2(REGS)-1:0] ra1_i,
   output logic [W-1:0]            rd1_o,
   input  logic [$clog2(REGS)-1:0] ra2_i,
   output logic [W-1:0]            rd2_o
);

   logic [W-1:0] mem_q [REGS];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rd0_o = mem_q[ra0_i];
   assign rd1_o = mem_q[ra1_i];
   assign rd2_o = mem_q[ra2_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external ALU: fetches operands,
// captures the ALU response and writes back the result or updates a flag.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int REGS = 4,
   parameter int W    = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   alu_sequencer_if.slave          instr_if,
   input  logic                    ld_en_i,
   input  logic [$clog2(REGS)-1:0] ld_addr_i,
   input  logic [W-1:0]            ld_data_i,
   input  logic [$clog2(REGS)-1:0] rd_addr_i,
   output logic [W-1:0]            rd_data_o,
   output logic [W-1:0]            alu_rs_o,
   output logic [W-1:0]            alu_rt_o,
   output logic [2:0]              alu_op_o,
   input  logic [W-1:0]            alu_result_i,
   input  logic                    alu_set_i,
   input  logic                    alu_zero_i,
   output logic                    set_flag_o,
   output logic                    zero_flag_o,
   output logic                    done_o
);

   localparam int AW = $clog2(REGS);

   state_t         state_q, state_d;
   logic           accept;
   logic           ld_take;
   logic           wb_write;
   logic           wr_en;
   logic [AW-1:0]  rs_addr, rt_addr, rs_q, wr_addr;
   logic [W-1:0]   rf_rs, rf_rt, wr_data;
   logic [W-1:0]   alu_rs_d, alu_rt_d, alu_rs_q, alu_rt_q, res_q;
   opcode_t        alu_op_q;
   logic           set_cap_q, zero_cap_q, set_flag_q, zero_flag_q;

   assign rs_addr = AW'(instr_if.instr_i[RS_MSB:RS_LSB]);
   assign rt_addr = AW'(instr_if.instr_i[RT_MSB:RT_LSB]);

   assign instr_if.instr_ready_o = (state_q == ST_IDLE);
   assign accept   = instr_if.instr_valid_i && (state_q == ST_IDLE);
   assign ld_take  = ld_en_i && (state_q == ST_IDLE);
   assign wb_write = (state_q == ST_WB) && op_writes_reg(alu_op_q);
   assign wr_en    = ld_take || wb_write;
   assign wr_addr  = wb_write ? rs_q  : ld_addr_i;
   assign wr_data  = wb_write ? res_q : ld_data_i;

   alu_regfile #(.REGS(REGS), .W(W)) u_regfile (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .ra0_i   (rs_addr),
      .rd0_o   (rf_rs),
      .ra1_i   (rt_addr),
      .rd1_o   (rf_rt),
      .ra2_i   (rd_addr_i),
      .rd2_o   (rd_data_o)
   );

   // A host load landing on the same edge as the accept is forwarded so the
   // instruction sees the freshly loaded value.
   assign alu_rs_d = (ld_take && (ld_addr_i == rs_addr)) ? ld_data_i : rf_rs;
   assign alu_rt_d = (ld_take && (ld_addr_i == rt_addr)) ? ld_data_i : rf_rt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         alu_op_q    <= '0;
         rs_q        <= '0;
         alu_rs_q    <= '0;
         alu_rt_q    <= '0;
         res_q       <= '0;
         set_cap_q   <= 1'b0;
         zero_cap_q  <= 1'b0;
         set_flag_q  <= 1'b0;
         zero_flag_q <= 1'b0;
      end else begin
         if (accept) begin
            alu_op_q <= opcode_t'(instr_if.instr_i[OP_MSB:OP_LSB]);
            rs_q     <= rs_addr;
            alu_rs_q <= alu_rs_d;
            alu_rt_q <= alu_rt_d;
         end
         if (state_q == ST_EXEC) begin
            res_q      <= alu_result_i;
            set_cap_q  <= alu_set_i;
            zero_cap_q <= alu_zero_i;
         end
         if (state_q == ST_WB) begin
            if (alu_op_q == OP_SET)  set_flag_q  <= set_cap_q;
            if (alu_op_q == OP_ZERO) zero_flag_q <= zero_cap_q;
         end
      end
   end

   assign alu_op_o    = alu_op_q;
   assign alu_rs_o    = alu_rs_q;
   assign alu_rt_o    = alu_rt_q;
   assign set_flag_o  = set_flag_q;
   assign zero_flag_o = zero_flag_q;
   assign done_o      = (state_q == ST_WB);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with a small combinational ALU model.
module tb_alu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] alu_rs, alu_rt, alu_result;
   logic [2:0] alu_op;
   logic       alu_set, alu_zero;
   logic       set_flag, zero_flag, done;

   int checks   = 0;
   int failures = 0;
   int accepts;
   int dones;

   alu_sequencer_if sif ();

   alu_sequencer #(.REGS(4), .W(8)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .instr_if     (sif),
      .ld_en_i      (ld_en),
      .ld_addr_i    (ld_addr),
      .ld_data_i    (ld_data),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .alu_rs_o     (alu_rs),
      .alu_rt_o     (alu_rt),
      .alu_op_o     (alu_op),
      .alu_result_i (alu_result),
      .alu_set_i    (alu_set),
      .alu_zero_i   (alu_zero),
      .set_flag_o   (set_flag),
      .zero_flag_o  (zero_flag),
      .done_o       (done)
   );

   // ALU: add, sub, and, or, xor, sub(set), shl1, sub(zero); set = unsigned rs<rt.
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         3'b000:  alu_result = alu_rs + alu_rt;
         3'b001:  alu_result = alu_rs - alu_rt;
         3'b010:  alu_result = alu_rs & alu_rt;
         3'b011:  alu_result = alu_rs | alu_rt;
         3'b100:  alu_result = alu_rs ^ alu_rt;
         3'b110:  alu_result = {alu_rs[6:0], 1'b0};
         default: alu_result = alu_rs - alu_rt;
      endcase
      alu_set  = (alu_rs < alu_rt);
      alu_zero = (alu_result == 8'h00);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic issue(input logic [7:0] ins);
      sif.instr_valid_i = 1'b1; sif.instr_i = ins;
      tick();
      sif.instr_valid_i = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   function automatic logic [7:0] mk(input logic [2:0] op, input logic [1:0] rs,
                                     input logic [1:0] rt, input logic b0);
      return {op, rs, rt, b0};
   endfunction

   logic [7:0] prog [3];

   initial begin
      rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
      sif.instr_valid_i = 1'b0; sif.instr_i = '0;
      #3;
      check("rst_done", 32'(done), 32'd0);
      check("rst_alu_rs", 32'(alu_rs), 32'd0);
      check("rst_flags", 32'({set_flag, zero_flag}), 32'd0);
      tick();
      rst_n = 1'b1;
      check("ready_after_rst", 32'(sif.instr_ready_o), 32'd1);

      // ADD r0 <- r0 + r1
      load(2'd0, 8'h55);
      load(2'd1, 8'hAA);
      issue(mk(3'b000, 2'd0, 2'd1, 1'b0));
      check("exec_op", 32'(alu_op), 32'd0);
      check("exec_rs", 32'(alu_rs), 32'h55);
      check("exec_rt", 32'(alu_rt), 32'hAA);
      check("exec_ready", 32'(sif.instr_ready_o), 32'd0);
      check("exec_done", 32'(done), 32'd0);
      tick();
      check("wb_done", 32'(done), 32'd1);
      tick();
      check("idle_done", 32'(done), 32'd0);
      rdchk("add_r0", 2'd0, 8'hFF);
      check("hold_rs", 32'(alu_rs), 32'h55);

      // rs == rt, bit0 set: r1 <- 0xAA + 0xAA
      issue(mk(3'b000, 2'd1, 2'd1, 1'b1));
      check("same_rs", 32'(alu_rs), 32'hAA);
      check("same_rt", 32'(alu_rt), 32'hAA);
      tick(); tick();
      rdchk("same_r1", 2'd1, 8'h54);

      // SET with 1 < 2
      load(2'd2, 8'h01);
      load(2'd3, 8'h02);
      issue(mk(3'b101, 2'd2, 2'd3, 1'b0));
      tick(); tick();
      check("set_flag_1", 32'(set_flag), 32'd1);
      rdchk("set_r2_kept", 2'd2, 8'h01);

      // ZERO with equal operands
      load(2'd0, 8'hFF);
      load(2'd1, 8'hFF);
      issue(mk(3'b111, 2'd0, 2'd1, 1'b0));
      tick(); tick();
      check("zero_flag_1", 32'(zero_flag), 32'd1);
      check("zero_keeps_set", 32'(set_flag), 32'd1);
      rdchk("zero_r0_kept", 2'd0, 8'hFF);
      rdchk("zero_r1_kept", 2'd1, 8'hFF);

      // SET with 1 < 1 false
      load(2'd3, 8'h01);
      issue(mk(3'b101, 2'd2, 2'd3, 1'b0));
      tick(); tick();
      check("set_flag_0", 32'(set_flag), 32'd0);
      check("set_keeps_zero", 32'(zero_flag), 32'd1);
      rdchk("set_r2_kept2", 2'd2, 8'h01);

      // Back-to-back with valid held high for 9 cycles
      load(2'd2, 8'h0F);
      load(2'd3, 8'hF0);
      prog[0] = mk(3'b010, 2'd2, 2'd3, 1'b0);
      prog[1] = mk(3'b011, 2'd3, 2'd2, 1'b0);
      prog[2] = mk(3'b100, 2'd3, 2'd1, 1'b0);
      accepts = 0; dones = 0;
      for (int i = 0; i < 9; i++) begin
         sif.instr_valid_i = 1'b1;
         sif.instr_i = prog[i / 3];
         #1;
         check($sformatf("b2b_ready_%0d", i), 32'(sif.instr_ready_o), 32'((i % 3) == 0));
         if (sif.instr_ready_o) accepts++;
         if (done) dones++;
         tick();
      end
      sif.instr_valid_i = 1'b0;
      check("b2b_accepts", 32'(accepts), 32'd3);
      check("b2b_dones", 32'(dones), 32'd3);
      rdchk("b2b_r2", 2'd2, 8'h00);
      rdchk("b2b_r3", 2'd3, 8'h0F);

      // Reset during EXEC
      load(2'd0, 8'h11);
      issue(mk(3'b110, 2'd0, 2'd0, 1'b0));
      check("pre_rst_rs", 32'(alu_rs), 32'h11);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rs", 32'(alu_rs), 32'd0);
      check("arst_rt", 32'(alu_rt), 32'd0);
      check("arst_op", 32'(alu_op), 32'd0);
      check("arst_flags", 32'({set_flag, zero_flag}), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      check("rel_ready", 32'(sif.instr_ready_o), 32'd1);
      tick(); tick(); tick();
      check("rel_done", 32'(done), 32'd0);
      for (int r = 0; r < 4; r++) begin
         rdchk($sformatf("rel_r%0d", r), 2'(r), 8'h00);
      end

      // Load during WB is ignored; load with accept is forwarded
      load(2'd1, 8'h77);
      issue(mk(3'b111, 2'd0, 2'd0, 1'b0));
      tick();
      check("wb_done2", 32'(done), 32'd1);
      ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h3C;
      tick();
      ld_en = 1'b0;
      rdchk("wb_load_ignored", 2'd1, 8'h77);
      ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h3C;
      issue(mk(3'b000, 2'd1, 2'd0, 1'b0));
      ld_en = 1'b0;
      check("fwd_rs", 32'(alu_rs), 32'h3C);
      rdchk("fwd_r1", 2'd1, 8'h3C);
      tick(); tick();
      rdchk("fwd_result", 2'd1, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter REGS, default 4, number of 8-bit general registers (power of 2, min 2).
REQ-002 SHALL have parameter W, default 8, datapath width matching the ALU.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid_i  input  1  instruction offered.
REQ-006 instr_i  input  8  instruction: [7:5] opcode, [4:3] rs (also destination), [2:1] rt, [0] reserved (ignored).
REQ-007 instr_ready_o  output  1  sequencer can accept an instruction.
REQ-008 ld_en_i / ld_addr_i / ld_data_i  input  1 / log2(REGS) / W  host register load.
REQ-009 rd_addr_i  input  log2(REGS)  host read select; rd_data_o  output  W  combinational register read.
REQ-010 alu_rs_o / alu_rt_o / alu_op_o  output  W / W / 3  registered drive to ALU operand and opcode ports.
REQ-011 alu_result_i / alu_set_i / alu_zero_i  input  W / 1 / 1  combinational ALU response.
REQ-012 set_flag_o, zero_flag_o  output  1 each  registered flags; done_o  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, WB; transitions IDLE->EXEC on accept, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-014 instr_ready_o SHALL be 1 only in IDLE; accept = instr_valid_i & instr_ready_o at a rising edge; instruction is latched on accept.
REQ-015 instr_valid_i outside IDLE SHALL be ignored; no queuing.
REQ-016 On entering EXEC, alu_op_o, alu_rs_o = reg[rs], alu_rt_o = reg[rt] SHALL be registered, and SHALL hold those values until the next accept.
REQ-017 At the EXEC->WB edge, alu_result_i, alu_set_i and alu_zero_i SHALL be captured.
REQ-018 For opcodes 000, 001, 010, 011, 100, 110, the captured result SHALL be written to reg[rs] at the WB->IDLE edge; flags unchanged.
REQ-019 For opcode 101, set_flag_o SHALL take the captured set value; no register write.
REQ-020 For opcode 111, zero_flag_o SHALL take the captured zero value; no register write.
REQ-021 done_o SHALL be 1 exactly during WB; latency accept edge to done_o high = 2 cycles; back-to-back throughput = one instruction per 3 cycles.
REQ-022 Host load SHALL take effect only in IDLE; ld_en_i in EXEC/WB SHALL be ignored.
REQ-023 Load and accept at the same IDLE edge: load SHALL be written and the instruction SHALL see the loaded value, because operands are read on entry to EXEC.
REQ-024 rs == rt SHALL drive the same value on both operand ports.
REQ-025 rd_data_o SHALL reflect a WB write from the cycle after the write edge.
REQ-026 Bit 0 of instr_i SHALL have no effect.

Reset
REQ-027 Asserting rst_n_i low at any time, including in EXEC or WB, SHALL immediately force IDLE, all registers 0, alu_rs_o/alu_rt_o/alu_op_o 0, flags 0, done_o 0.
REQ-028 An instruction in flight at reset SHALL be discarded with no register write.
REQ-029 instr_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode constants (OP_SET = 3'b101, OP_ZERO = 3'b111, and the others), the instruction field bit positions, and the FSM state enum.
REQ-031 The register file SHALL be one sub-module, alu_regfile: 1 synchronous write port, 3 combinational read ports, asynchronous active-low clear.
REQ-032 The ALU SHALL stay external; the sequencer SHALL contain no arithmetic.

Verification
REQ-033 Bench SHALL pair the sequencer with the existing ALU and cover these scenarios:
REQ-034 Load r0=0x55, r1=0xAA; instr op000 rs0 rt1 -> alu_op_o=000, alu_rs_o=0x55, alu_rt_o=0xAA in EXEC; done_o at accept+2; r0 = ALU result afterwards.
REQ-035 r2=0x01, r3=0x01; op101 rs2 rt3 -> set_flag_o = alu_set_i; r2 still 0x01.
REQ-036 r0=r1=0xFF; op111 rs0 rt1 -> zero_flag_o = alu_zero_i; no register changes.
REQ-037 instr_valid_i held high for 9 cycles with 3 distinct instructions -> exactly 3 accepts, 3 done_o pulses; instr_ready_o 1,0,0 repeating.
REQ-038 Reset asserted mid-EXEC -> all outputs 0 asynchronously; after release, r0..r3 = 0 and no write from the aborted instruction.
REQ-039 ld_en_i with ld_addr_i=1, ld_data_i=0x3C in WB -> r1 unchanged; the same load together with an accept in IDLE -> alu_rs_o=0x3C for rs=1.
